// File: rtl/bus_master.sv
// bus_master
// ----------
// Synchronous initiator for the system device bus. Accepts single-word
// read/write requests from the core on a REQ/READY/ACK handshake and turns
// each one into a SETUP -> STROBE -> RECOVER sequence on the device bus.
// Every output, including the BUS_D drive enable, comes from a flop.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   synchronous active-high reset
//   REQ      in   request strobe, sampled only while READY=1
//   REQ_WE   in   1 = write, 0 = read
//   REQ_A    in   request address   [ADDR_W]
//   REQ_D    in   write data        [DATA_W]
//   READY    out  idle, a REQ on this cycle's edge is accepted
//   ACK      out  one-cycle completion pulse
//   RD_D     out  last captured read data [DATA_W]
//   BUS_A    out  bus address [ADDR_W]
//   BUS_D    io   bus data, driven only by write transactions [DATA_W]
//   BUS_R    out  read strobe
//   BUS_W    out  write strobe

module bus_master #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 16,
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 5,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_A,
    input  logic [DATA_W-1:0] REQ_D,
    output logic              READY,
    output logic              ACK,
    output logic [DATA_W-1:0] RD_D,
    output logic [ADDR_W-1:0] BUS_A,
    inout  wire  [DATA_W-1:0] BUS_D,
    output logic              BUS_R,
    output logic              BUS_W
);

    // One shared down-counter times all three phases, so it only has to
    // hold the largest phase length minus one.
    localparam int MAX_SU = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_T  = (MAX_SU > RECOVER_CYCLES) ? MAX_SU : RECOVER_CYCLES;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RECOVER
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_write;
    logic                drive_en;
    logic [DATA_W-1:0]   wr_data;

    // The master only ever drives the data bus from the accept edge of a
    // write until the edge leaving RECOVER; reads and idle leave it floating.
    assign BUS_D = drive_en ? wr_data : {DATA_W{1'bz}};

    // Transaction sequencer. The drive enable is raised on the accept edge
    // so write data is already stable for the whole SETUP phase. Read data
    // is captured on the same edge that drops BUS_R, while the device is
    // still guaranteed to be driving.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_write <= 1'b0;
            drive_en <= 1'b0;
            wr_data  <= '0;
            READY    <= 1'b1;
            ACK      <= 1'b0;
            RD_D     <= '0;
            BUS_A    <= '0;
            BUS_R    <= 1'b0;
            BUS_W    <= 1'b0;
        end else begin
            ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        is_write <= REQ_WE;
                        wr_data  <= REQ_D;
                        BUS_A    <= REQ_A;
                        drive_en <= REQ_WE;
                        READY    <= 1'b0;
                        cnt      <= SETUP_LOAD;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        BUS_R <= ~is_write;
                        BUS_W <= is_write;
                        cnt   <= STROBE_LOAD;
                        state <= ST_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        BUS_R <= 1'b0;
                        BUS_W <= 1'b0;
                        if (!is_write) begin
                            RD_D <= BUS_D;
                        end
                        cnt   <= RECOVER_LOAD;
                        state <= ST_RECOVER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt == '0) begin
                        ACK      <= 1'b1;
                        READY    <= 1'b1;
                        drive_en <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master
// -------------
// Self-checking bench for bus_master. A small device model answers reads
// from dev_mem and stores writes; ref_mem and last_rd form the reference
// model of what the bus should contain and what RD_D should show. A
// pullup on the data bus makes "nobody drives" read back as all ones.
`timescale 1ns/1ps

module tb_bus_master;

    localparam int             AW   = 23;
    localparam int             DW   = 16;
    localparam int             LAT  = 10;
    localparam int             STB  = 5;
    localparam logic [DW-1:0]  PULL = 16'hFFFF;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          req    = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_a  = '0;
    logic [DW-1:0] req_d  = '0;
    logic          ready;
    logic          ack;
    logic          bus_r;
    logic          bus_w;
    logic [DW-1:0] rd_d;
    logic [AW-1:0] bus_a;
    wire  [DW-1:0] bus_d;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] dev_mem [16];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] last_rd;

    typedef struct {
        int            lat;
        int            stb_start;
        int            stb_len;
        int            wrong;
        int            drive_bad;
        logic          rel_ok;
        logic          ready_ok;
        logic          ack_one;
        logic [DW-1:0] rd;
    } obs_t;

    bus_master dut (
        .CLK   (clk),
        .RESET (reset),
        .REQ   (req),
        .REQ_WE(req_we),
        .REQ_A (req_a),
        .REQ_D (req_d),
        .READY (ready),
        .ACK   (ack),
        .RD_D  (rd_d),
        .BUS_A (bus_a),
        .BUS_D (bus_d),
        .BUS_R (bus_r),
        .BUS_W (bus_w)
    );

    always #5 clk = ~clk;

    pullup pu_bus_d (bus_d);

    // Device model: drives data while BUS_R is high, stores on BUS_W.
    assign bus_d = bus_r ? dev_mem[bus_a[3:0]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (bus_w) dev_mem[bus_a[3:0]] <= bus_d;
    end

    // Issue one access from idle and watch it until ACK (bounded).
    // Cycle k is the negedge after the k-th edge following the accept edge.
    task automatic run_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output obs_t o);
        logic stb;
        logic oth;
        o.lat = -1; o.stb_start = -1; o.stb_len = 0; o.wrong = 0;
        o.drive_bad = 0; o.rel_ok = 1'b0; o.ready_ok = 1'b0; o.ack_one = 1'b0;
        o.rd = 'x;
        @(negedge clk);
        req = 1'b1; req_we = we; req_a = a; req_d = d;
        @(negedge clk);
        req = 1'b0; req_we = 1'($urandom); req_a = AW'($urandom); req_d = DW'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (ack) begin
                o.lat = k; o.rd = rd_d;
                o.rel_ok = (bus_d === PULL); o.ready_ok = (ready === 1'b1);
                break;
            end
            stb = we ? bus_w : bus_r;
            oth = we ? bus_r : bus_w;
            if (stb) begin
                if (o.stb_start < 0) o.stb_start = k;
                o.stb_len++;
            end
            if (oth) o.wrong++;
            if (we ? (bus_d !== d) : (!bus_r && bus_d !== PULL)) o.drive_bad++;
        end
        @(negedge clk);
        o.ack_one = (ack === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_r, bus_w, ack, ready} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_ctrl actual r/w/ack/ready=%b expected=0001", {bus_r, bus_w, ack, ready});
        end
        checks++;
        if (bus_a !== '0) begin
            failures++; $display("[TB] FAIL reset_bus_a actual=%h expected=0", bus_a);
        end
        checks++;
        if (rd_d !== '0) begin
            failures++; $display("[TB] FAIL reset_rd_d actual=%h expected=0", rd_d);
        end
        checks++;
        if (bus_d !== PULL) begin
            failures++; $display("[TB] FAIL reset_bus_d_undriven actual=%h expected=%h", bus_d, PULL);
        end
        reset = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_read();
        obs_t o;
        run_access(1'b0, '0, '0, o);
        checks++;
        if (o.lat !== LAT) begin failures++; $display("[TB] FAIL read_latency actual=%0d expected=%0d", o.lat, LAT); end
        checks++;
        if (o.stb_start !== 1 || o.stb_len !== STB) begin
            failures++; $display("[TB] FAIL read_strobe actual start=%0d len=%0d expected start=1 len=%0d", o.stb_start, o.stb_len, STB);
        end
        checks++;
        if (o.rd !== ref_mem[0]) begin failures++; $display("[TB] FAIL read_data actual=%h expected=%h", o.rd, ref_mem[0]); end
        checks++;
        if (o.drive_bad !== 0 || o.wrong !== 0) begin
            failures++; $display("[TB] FAIL read_bus_hygiene actual drive_bad=%0d wrong_strobe=%0d expected 0/0", o.drive_bad, o.wrong);
        end
        checks++;
        if (!(o.ready_ok && o.ack_one)) begin
            failures++; $display("[TB] FAIL read_ack_pulse actual ready=%b single=%b expected 1/1", o.ready_ok, o.ack_one);
        end
        last_rd = ref_mem[0];
    endtask

    task automatic test_write_readback();
        obs_t o;
        logic [DW-1:0] wd [2];
        wd[0] = 16'h4321; wd[1] = 16'hDCBA;
        for (int i = 0; i < 2; i++) begin
            run_access(1'b1, AW'(i), wd[i], o);
            ref_mem[i] = wd[i];
            checks++;
            if (o.lat !== LAT || o.stb_start !== 1 || o.stb_len !== STB) begin
                failures++; $display("[TB] FAIL write_timing[%0d] actual lat=%0d start=%0d len=%0d expected %0d/1/%0d", i, o.lat, o.stb_start, o.stb_len, LAT, STB);
            end
            checks++;
            if (o.drive_bad !== 0 || o.wrong !== 0 || !o.rel_ok) begin
                failures++; $display("[TB] FAIL write_data_hold[%0d] actual bad=%0d wrong=%0d released=%b expected 0/0/1", i, o.drive_bad, o.wrong, o.rel_ok);
            end
            checks++;
            if (o.rd !== last_rd) begin failures++; $display("[TB] FAIL write_keeps_rd_d[%0d] actual=%h expected=%h", i, o.rd, last_rd); end
        end
        for (int i = 0; i < 2; i++) begin
            run_access(1'b0, AW'(i), '0, o);
            checks++;
            if (o.rd !== ref_mem[i]) begin failures++; $display("[TB] FAIL readback[%0d] actual=%h expected=%h", i, o.rd, ref_mem[i]); end
            last_rd = ref_mem[i];
        end
    endtask

    // REQ held high: each new access is accepted on the edge that ends the
    // previous ACK cycle, so successive ACKs are LAT+1 cycles apart (ten
    // non-ACK cycles between pulses).
    task automatic test_back_to_back();
        int ack_cyc [3];
        logic [DW-1:0] rds [3];
        int acks = 0, acc = 0, run = 0, bad_runs = 0, n_runs = 0, r_on_ack = 0;
        logic pend;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_a = '0;
        pend = ready;
        for (int cyc = 0; cyc < 80 && acks < 3; cyc++) begin
            @(negedge clk);
            if (pend) begin
                acc++; pend = 1'b0;
                if (acc < 3) req_a = AW'(acc); else req = 1'b0;
            end
            if (bus_r) run++;
            else if (run > 0) begin n_runs++; if (run != STB) bad_runs++; run = 0; end
            if (ack) begin
                if (bus_r) r_on_ack++;
                ack_cyc[acks] = cyc; rds[acks] = rd_d; acks++;
            end
            if (ready && req) pend = 1'b1;
        end
        checks++;
        if (acks !== 3) begin failures++; $display("[TB] FAIL b2b_ack_count actual=%0d expected=3", acks); end
        for (int i = 1; i < acks; i++) begin
            checks++;
            if (ack_cyc[i] - ack_cyc[i-1] !== LAT + 1) begin
                failures++; $display("[TB] FAIL b2b_spacing[%0d] actual=%0d expected=%0d", i, ack_cyc[i] - ack_cyc[i-1], LAT + 1);
            end
        end
        for (int i = 0; i < acks; i++) begin
            checks++;
            if (rds[i] !== ref_mem[i]) begin failures++; $display("[TB] FAIL b2b_data[%0d] actual=%h expected=%h", i, rds[i], ref_mem[i]); end
        end
        checks++;
        if (n_runs !== 3 || bad_runs !== 0 || r_on_ack !== 0) begin
            failures++; $display("[TB] FAIL b2b_strobe_runs actual runs=%0d bad=%0d r_on_ack=%0d expected 3/0/0", n_runs, bad_runs, r_on_ack);
        end
        if (acks > 0) last_rd = rds[acks-1];
    endtask

    task automatic test_busy_ignore();
        obs_t o;
        int acks = 0, wcnt = 0;
        logic [DW-1:0] got = 'x;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_a = AW'(3);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_a = AW'(5); req_d = 16'hBEEF;
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack) begin acks++; got = rd_d; end
            if (bus_w) wcnt++;
        end
        checks++;
        if (acks !== 1 || wcnt !== 0) begin
            failures++; $display("[TB] FAIL busy_ignore actual acks=%0d write_cycles=%0d expected 1/0", acks, wcnt);
        end
        checks++;
        if (got !== ref_mem[3] || ready !== 1'b1) begin
            failures++; $display("[TB] FAIL busy_read actual data=%h ready=%b expected %h/1", got, ready, ref_mem[3]);
        end
        run_access(1'b0, AW'(5), '0, o);
        checks++;
        if (o.rd !== ref_mem[5]) begin failures++; $display("[TB] FAIL busy_mem5_unchanged actual=%h expected=%h", o.rd, ref_mem[5]); end
        last_rd = ref_mem[5];
    endtask

    task automatic test_random();
        obs_t o;
        logic we;
        int a;
        logic [DW-1:0] d;
        for (int i = 0; i < 12; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 13);
            d  = DW'($urandom_range(0, 16'hFFFE));
            run_access(we, AW'(a), d, o);
            checks++;
            if (o.lat !== LAT || o.stb_len !== STB || o.wrong !== 0 || o.drive_bad !== 0) begin
                failures++; $display("[TB] FAIL rand_timing[%0d] actual lat=%0d len=%0d wrong=%0d bad=%0d", i, o.lat, o.stb_len, o.wrong, o.drive_bad);
            end
            if (we) ref_mem[a] = d;
            else    last_rd = ref_mem[a];
            checks++;
            if (o.rd !== last_rd) begin
                failures++; $display("[TB] FAIL rand_rd_d[%0d] we=%b addr=%0d actual=%h expected=%h", i, we, a, o.rd, last_rd);
            end
        end
    endtask

    // Reset lands on the edge that ends the third write-strobe cycle.
    task automatic test_reset_mid_strobe();
        obs_t o;
        int acks = 0;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_a = AW'(14); req_d = 16'h5A5A;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_w !== 1'b0 || bus_d !== PULL || ack !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_bus actual bus_w=%b bus_d=%h ack=%b expected 0/%h/0", bus_w, bus_d, ack, PULL);
        end
        checks++;
        if (ready !== 1'b1 || rd_d !== '0) begin
            failures++; $display("[TB] FAIL abort_state actual ready=%b rd_d=%h expected 1/0", ready, rd_d);
        end
        reset = 1'b0;
        last_rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        checks++;
        if (acks !== 0) begin failures++; $display("[TB] FAIL abort_no_ack actual=%0d expected=0", acks); end
        run_access(1'b0, AW'(1), '0, o);
        checks++;
        if (o.lat !== LAT || o.rd !== ref_mem[1]) begin
            failures++; $display("[TB] FAIL post_abort_read actual lat=%0d data=%h expected %0d/%h", o.lat, o.rd, LAT, ref_mem[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = (i == 0) ? 16'h1234 : DW'(16'hA000 + i);
            ref_mem[i] = dev_mem[i];
        end
        test_reset();
        test_read();
        test_write_readback();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        test_reset_mid_strobe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
